// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - streams instruction words into instruction memory while holding the CPU in reset
module imem_loader #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [31:0]       in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              overflow_err,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE,
        ERROR
    } state_t;

    localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

    state_t          state;
    state_t          state_nxt;
    logic [ADDR_W:0] count_nxt;
    logic            handshake;
    logic            room;
    logic            write;

    assign in_ready  = (state == LOAD);
    assign handshake = in_valid & in_ready;
    assign room      = (word_count < FULL);
    assign write     = handshake & room;

    always_comb begin
        state_nxt = state;
        count_nxt = word_count;
        case (state)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_nxt = LOAD;
                    count_nxt = '0;
                end
            end
            LOAD: begin
                if (handshake) begin
                    if (!room) begin
                        // memory is full: nothing more is written, marker or not
                        state_nxt = ERROR;
                    end else begin
                        count_nxt = word_count + 1'b1;
                        if (in_data == 32'h0000_0000) begin
                            state_nxt = DONE;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            word_count   <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            done         <= 1'b0;
            cpu_hold     <= 1'b1;
            overflow_err <= 1'b0;
        end else begin
            state      <= state_nxt;
            word_count <= count_nxt;
            mem_we     <= write;
            if (write) begin
                mem_addr  <= word_count[ADDR_W-1:0];
                mem_wdata <= in_data;
            end
            // status flags lag the state by a cycle so the CPU is released only after the last write
            done         <= (state == DONE);
            cpu_hold     <= (state != DONE);
            overflow_err <= (state == ERROR);
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed vector bench for imem_loader
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, in_valid;
    logic [31:0] in_data;
    logic        in_ready, mem_we, cpu_hold, done, overflow_err;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [10:0] word_count;

    logic        s_start, s_valid;
    logic [31:0] s_data;
    logic        s_ready, s_we, s_hold, s_done, s_ovf;
    logic [1:0]  s_addr;
    logic [31:0] s_wdata;
    logic [2:0]  s_wc;

    int ncmp = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    imem_loader dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .done(done), .overflow_err(overflow_err), .word_count(word_count)
    );

    imem_loader #(.DEPTH(4), .ADDR_W(2)) dut_s (
        .clk(clk), .reset(reset), .start(s_start), .in_valid(s_valid), .in_data(s_data),
        .in_ready(s_ready), .mem_we(s_we), .mem_addr(s_addr), .mem_wdata(s_wdata),
        .cpu_hold(s_hold), .done(s_done), .overflow_err(s_ovf), .word_count(s_wc)
    );

    typedef struct {
        logic        start;
        logic        valid;
        logic [31:0] data;
        logic        e_ready;
        logic        e_we;
        logic [9:0]  e_addr;
        logic [31:0] e_wdata;
        logic [10:0] e_wc;
        logic        e_done;
        logic        e_hold;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " in_ready"},     32'(in_ready),     32'd0);
        chk({tag, " mem_we"},       32'(mem_we),       32'd0);
        chk({tag, " mem_addr"},     32'(mem_addr),     32'd0);
        chk({tag, " mem_wdata"},    mem_wdata,         32'd0);
        chk({tag, " cpu_hold"},     32'(cpu_hold),     32'd1);
        chk({tag, " done"},         32'(done),         32'd0);
        chk({tag, " overflow_err"}, 32'(overflow_err), 32'd0);
        chk({tag, " word_count"},   32'(word_count),   32'd0);
    endtask

    task automatic run_vec(input vec_t v, input int n);
        @(negedge clk);
        start    = v.start;
        in_valid = v.valid;
        in_data  = v.data;
        @(posedge clk);
        #1;
        chk($sformatf("v%0d in_ready", n),   32'(in_ready),   32'(v.e_ready));
        chk($sformatf("v%0d mem_we", n),     32'(mem_we),     32'(v.e_we));
        chk($sformatf("v%0d mem_addr", n),   32'(mem_addr),   32'(v.e_addr));
        chk($sformatf("v%0d mem_wdata", n),  mem_wdata,       v.e_wdata);
        chk($sformatf("v%0d word_count", n), 32'(word_count), 32'(v.e_wc));
        chk($sformatf("v%0d done", n),       32'(done),       32'(v.e_done));
        chk($sformatf("v%0d cpu_hold", n),   32'(cpu_hold),   32'(v.e_hold));
    endtask

    logic [31:0] prog [12];
    logic [31:0] bw   [9];
    vec_t        tv   [16];

    initial begin
        int idx;
        int budget;
        int nwr;
        logic exp_hs;

        prog = '{32'h00500093, 32'h00300113, 32'h002081b3, 32'h40208233,
                 32'h0041f2b3, 32'h0041e333, 32'h0062c3b3, 32'h00239413,
                 32'h0013d493, 32'h00802023, 32'h00002503, 32'h00000000};
        bw   = '{32'hC0DE0001, 32'hC0DE0002, 32'hC0DE0003, 32'hC0DE0004,
                 32'hC0DE0005, 32'hC0DE0006, 32'hC0DE0007, 32'hC0DE0008, 32'h00000000};

        tv[0] = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 10'd0, 32'h0, 11'd0, 1'b0, 1'b1};
        for (int k = 0; k < 12; k++) begin
            tv[k+1] = '{1'b0, 1'b1, prog[k], (k < 11), 1'b1, 10'(k), prog[k], 11'(k + 1), 1'b0, 1'b1};
        end
        tv[13] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 10'd11, 32'h0, 11'd12, 1'b1, 1'b0};
        tv[14] = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 10'd11, 32'h0, 11'd0,  1'b1, 1'b0};
        tv[15] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 10'd11, 32'h0, 11'd0,  1'b0, 1'b1};

        start = 1'b0; in_valid = 1'b0; in_data = 32'h0;
        s_start = 1'b0; s_valid = 1'b0; s_data = 32'h0;

        // asynchronous reset between edges
        reset = 1'b1;
        #1 reset = 1'b0;
        #1 chk_reset("por");
        chk("por s_cpu_hold", 32'(s_hold), 32'd1);
        chk("por s_word_count", 32'(s_wc), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1 chk("idle in_ready", 32'(in_ready), 32'd0);
        end

        // nominal 12-word load, then reload from DONE
        for (int n = 0; n < 16; n++) run_vec(tv[n], n);

        // random backpressure: 8 words plus marker
        idx = 0;
        budget = 0;
        while (idx < 9 && budget < 300) begin
            @(negedge clk);
            in_valid = 1'($urandom_range(0, 1));
            in_data  = bw[idx];
            exp_hs   = in_valid;
            chk("bp in_ready", 32'(in_ready), 32'd1);
            @(posedge clk);
            #1;
            chk("bp mem_we", 32'(mem_we), 32'(exp_hs));
            if (exp_hs) begin
                chk($sformatf("bp addr%0d", idx), 32'(mem_addr), 32'(idx));
                chk($sformatf("bp data%0d", idx), mem_wdata, bw[idx]);
                idx++;
            end
            chk("bp word_count", 32'(word_count), 32'(idx));
            budget++;
        end
        chk("bp timeout", 32'(idx), 32'd9);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("bp done", 32'(done), 32'd1);
        chk("bp cpu_hold", 32'(cpu_hold), 32'd0);
        chk("bp in_ready", 32'(in_ready), 32'd0);
        chk("bp final count", 32'(word_count), 32'd9);

        // reset during the 4th handshake of a session
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 chk("rm start ready", 32'(in_ready), 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            start = 1'b0; in_valid = 1'b1; in_data = 32'hA0000000 + 32'(k);
            @(posedge clk);
            #1;
            chk($sformatf("rm we%0d", k), 32'(mem_we), 32'd1);
            chk($sformatf("rm addr%0d", k), 32'(mem_addr), 32'(k));
            chk($sformatf("rm wc%0d", k), 32'(word_count), 32'(k + 1));
        end
        @(negedge clk);
        in_data = 32'hA0000003;
        #3 reset = 1'b0;
        #1 chk_reset("rm async");
        @(posedge clk);
        #1 chk_reset("rm held");
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1 chk("rm idle ready", 32'(in_ready), 32'd0);
            chk("rm idle hold", 32'(cpu_hold), 32'd1);
        end
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            start = 1'b0; in_valid = 1'b1; in_data = (k == 2) ? 32'h0 : 32'hB0000000 + 32'(k);
            @(posedge clk);
            #1;
            chk($sformatf("rl we%0d", k), 32'(mem_we), 32'd1);
            chk($sformatf("rl addr%0d", k), 32'(mem_addr), 32'(k));
            chk($sformatf("rl data%0d", k), mem_wdata, (k == 2) ? 32'h0 : 32'hB0000000 + 32'(k));
        end
        chk("rl word_count", 32'(word_count), 32'd3);
        @(negedge clk);
        in_valid = 1'b0;

        // overflow on the 4-word instance
        nwr = 0;
        @(negedge clk);
        s_start = 1'b1;
        @(posedge clk);
        #1 chk("ov start ready", 32'(s_ready), 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            s_start = 1'b0; s_valid = 1'b1; s_data = 32'h11 + 32'(k);
            @(posedge clk);
            #1;
            if (s_we) nwr++;
            if (k < 4) begin
                chk($sformatf("ov we%0d", k), 32'(s_we), 32'd1);
                chk($sformatf("ov addr%0d", k), 32'(s_addr), 32'(k));
                chk($sformatf("ov wc%0d", k), 32'(s_wc), 32'(k + 1));
            end else begin
                chk("ov 5th we", 32'(s_we), 32'd0);
                chk("ov 5th wc", 32'(s_wc), 32'd4);
                chk("ov 5th ready", 32'(s_ready), 32'd0);
                chk("ov lag err", 32'(s_ovf), 32'd0);
            end
        end
        @(negedge clk);
        s_valid = 1'b0;
        @(posedge clk);
        #1;
        if (s_we) nwr++;
        chk("ov overflow_err", 32'(s_ovf), 32'd1);
        chk("ov cpu_hold", 32'(s_hold), 32'd1);
        chk("ov done", 32'(s_done), 32'd0);
        chk("ov word_count", 32'(s_wc), 32'd4);
        chk("ov writes", 32'(nwr), 32'd4);
        @(negedge clk);
        s_start = 1'b1;
        @(posedge clk);
        #1;
        chk("ov restart ready", 32'(s_ready), 32'd1);
        chk("ov restart wc", 32'(s_wc), 32'd0);
        @(negedge clk);
        s_start = 1'b0;
        @(posedge clk);
        #1 chk("ov err cleared", 32'(s_ovf), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH, default 1024: number of 32-bit instruction-memory words.
REQ-002 Parameter ADDR_W, default 10: word-address width; DEPTH SHALL equal 2**ADDR_W.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = asserted).
REQ-005 start  input  1  begin a load session; sampled in IDLE, DONE and ERROR only.
REQ-006 in_valid  input  1  in_data holds an instruction word.
REQ-007 in_data  input  32  instruction word; 32'h00000000 is the halt/end marker.
REQ-008 in_ready  output  1  loader accepts a word this cycle.
REQ-009 mem_we  output  1  one-cycle write strobe to instruction memory.
REQ-010 mem_addr  output  ADDR_W  word address of the write.
REQ-011 mem_wdata  output  32  word to write.
REQ-012 cpu_hold  output  1  1 = hold the sequential CPU in reset.
REQ-013 done  output  1  program loaded successfully.
REQ-014 overflow_err  output  1  program exceeded DEPTH words.
REQ-015 word_count  output  ADDR_W+1  words written this session, halt marker included.

Function
REQ-016 States SHALL be IDLE, LOAD, DONE and ERROR, held in a registered state machine.
REQ-017 in_ready SHALL be combinational: 1 exactly when state==LOAD.
REQ-018 A handshake SHALL occur in a cycle only when in_valid & in_ready; no other cycle changes word_count or issues a write.
REQ-019 IDLE/DONE/ERROR with start=1 -> LOAD next cycle; word_count cleared to 0; overflow_err cleared.
REQ-020 start while in LOAD SHALL be ignored.
REQ-021 Handshake in cycle T with word_count<DEPTH: mem_we=1 in T+1 only; mem_addr=word_count(T)[ADDR_W-1:0]; mem_wdata=in_data(T); word_count increments at the T/T+1 edge.
REQ-022 Handshake in cycle T with in_data==0 and word_count<DEPTH: the marker is written per REQ-021, and state -> DONE at T+1 (in_ready=0 from T+1).
REQ-023 Handshake in cycle T with word_count==DEPTH: no write, word_count unchanged, state -> ERROR at T+1; this applies to any word, the marker included.
REQ-024 A marker handshake with word_count==DEPTH-1 SHALL go to DONE with word_count==DEPTH.
REQ-025 done and cpu_hold SHALL be registered from state, lagging it by one cycle: done=1 and cpu_hold=0 only while the previous-cycle state was DONE.
REQ-026 overflow_err SHALL be registered from state, lagging it by one cycle: 1 only while the previous-cycle state was ERROR.
REQ-027 In any state other than DONE, cpu_hold SHALL be 1, so the CPU never fetches from a partially written memory.
REQ-028 mem_addr and mem_wdata SHALL hold their last values when mem_we=0.
REQ-029 Back-to-back handshakes SHALL sustain one write per cycle with no bubbles.

Reset
REQ-030 reset=0 SHALL force immediately, regardless of clk: state=IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, done=0, overflow_err=0, word_count=0.
REQ-031 reset asserted mid-LOAD SHALL abandon the session; a write scheduled for the next cycle SHALL NOT occur; memory contents already written are not cleared.
REQ-032 After reset is released, the loader SHALL stay in IDLE until start=1.

Verification
REQ-033 Reset check: assert reset asynchronously between edges -> all outputs take the REQ-030 values before the next clk edge.
REQ-034 Nominal load: start, then 12 contiguous words (addi x1,x0,5 = 0x00500093 ... marker 0x00000000 last) -> 12 writes at addr 0..11, last mem_wdata=0, word_count=12, done=1 and cpu_hold=0 two cycles after the marker handshake.
REQ-035 Backpressure/gaps: in_valid random 50% over 8 words plus marker -> writes only on handshake cycles, addresses 0..8 contiguous, data in order, word_count=9.
REQ-036 Overflow (DEPTH=4, ADDR_W=2): 5 non-zero words -> exactly 4 writes (addr 0..3), 5th not written, overflow_err=1, cpu_hold=1, done=0, word_count=4.
REQ-037 Reset mid-load: 3 words accepted, reset asserted during the 4th handshake -> no 4th write, outputs at reset values; new start + 2 words + marker -> writes restart at addr 0, word_count=3.
REQ-038 Reload: in DONE assert start -> cpu_hold=1 and done=0 one cycle after state leaves DONE, word_count=0, in_ready=1 in the cycle after start.
